xphm_rd_stream: RTL and testbench

- Read-side engine for the XPHM simple-dual-port memory; the write side is filled by the header loader.
- On a start command, issues sequential reads of `len` words beginning at `base`, wrapping modulo DEPTH.
- Hides the fixed memory read latency behind a small credit-controlled output FIFO.
- Presents words on a valid/ready stream to the downstream datapath consumer.

---
 rtl/xphm_rd_stream.sv | 140 ++++++++++++++
 tb/tb_xphm_rd_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xphm_rd_stream.sv
// Sequential-read engine for XPHM: streams len words from base (wrapping) to a valid/ready consumer.
// Latency: start -> first read next cycle; first m_valid RD_LATENCY cycles after that read.
// Backpressure: m_ready stalls pops; reads stop while in-flight + buffered reaches FIFO_DEPTH.
module xphm_rd_stream #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 3,
    localparam int AW         = $clog2(DEPTH),
    localparam int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AW-1:0]         base,
    input  logic [AW:0]           len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                  state;
    logic [AW-1:0]           rd_addr;
    logic [AW:0]             len_q, issued_cnt, popped_cnt;
    logic [RD_LATENCY-1:0]   vld_sr;
    logic [RD_LATENCY:0]     vld_sr_nxt;
    logic [CW-1:0]           in_flight, fifo_count;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic                    credit_ok, push, pop, fifo_empty, fifo_wr, fifo_rd, last_pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered counts only, so the FIFO can always absorb every returning word.
    assign credit_ok   = (in_flight + fifo_count) < CW'(FIFO_DEPTH);
    assign mem_rd_en   = (state == ISSUE) && credit_ok;
    assign mem_rd_addr = rd_addr;
    assign push        = vld_sr[RD_LATENCY-1];
    assign vld_sr_nxt  = {vld_sr, mem_rd_en};

    // An empty FIFO passes the returning word straight through so it is visible the cycle it arrives.
    assign fifo_empty = (fifo_count == '0);
    assign m_valid    = !fifo_empty || push;
    assign m_data     = !fifo_empty ? fifo_mem[rd_ptr] : (push ? mem_dout : '0);
    assign pop        = m_valid && m_ready;
    assign fifo_wr    = push && !(fifo_empty && pop);
    assign fifo_rd    = pop && !fifo_empty;
    assign m_last     = m_valid && (popped_cnt == len_q - ONE);
    assign last_pop   = pop && (popped_cnt + ONE == len_q);

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            vld_sr     <= '0;
            in_flight  <= '0;
        end else begin
            vld_sr <= vld_sr_nxt[RD_LATENCY-1:0];
            if (fifo_wr)
                wr_ptr <= ptr_nxt(wr_ptr);
            if (fifo_rd)
                rd_ptr <= ptr_nxt(rd_ptr);
            fifo_count <= fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
            if (mem_rd_en && !push)
                in_flight <= in_flight + CW'(1);
            else if (!mem_rd_en && push)
                in_flight <= in_flight - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            len_q      <= '0;
            issued_cnt <= '0;
            popped_cnt <= '0;
        end else begin
            if (pop)
                popped_cnt <= popped_cnt + ONE;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr    <= base;
                        len_q      <= len;
                        issued_cnt <= '0;
                        popped_cnt <= '0;
                        busy       <= 1'b1;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_rd_en) begin
                        rd_addr    <= (rd_addr == AW'(DEPTH - 1)) ? '0 : rd_addr + AW'(1);
                        issued_cnt <= issued_cnt + ONE;
                        if (issued_cnt + ONE == len_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xphm_rd_stream.sv
// Scoreboard bench for xphm_rd_stream: expected addresses/words queued at start, popped by a monitor.
module tb_xphm_rd_stream;
    localparam int DW    = 512;
    localparam int DEPTH = 1024;
    localparam int L     = 3;
    localparam int AW    = 10;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, mem_rd_en, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_dout, m_data;
    logic [DW-1:0] pipe [L];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;
    exp_t exp_q[$];
    int   addr_q[$];
    int   n_rd = 0, n_pop = 0, done_cnt = 0;
    int   first_rd = -1, first_vld = -1, last_pop_cyc = -1, max_out = 0;
    logic          prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    xphm_rd_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last)
    );

    function automatic logic [DW-1:0] word(input int a);
        return DW'(a);
    endfunction

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory with fixed read latency L; unread slots return all-ones.
    initial forever begin
        @(posedge clk);
        for (int i = L - 1; i > 0; i--)
            pipe[i] <= pipe[i-1];
        pipe[0] <= mem_rd_en ? word(int'(mem_rd_addr)) : '1;
    end
    assign mem_dout = pipe[L-1];

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            default: m_ready = (cyc % 4 == 0);
        endcase
    end

    // Monitor: compares reads and handed-off words against the queued expectations.
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            prev_vld = 1'b0;
            continue;
        end
        if (n_rd - n_pop > max_out)
            max_out = n_rd - n_pop;
        if (done)
            done_cnt++;
        if (mem_rd_en) begin
            if (first_rd < 0)
                first_rd = cyc;
            if (addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: addr %0d with none expected", mem_rd_addr);
            end else begin
                check_int("rd_addr", int'(mem_rd_addr), addr_q.pop_front());
            end
            n_rd++;
        end
        if (m_valid) begin
            if (first_vld < 0)
                first_vld = cyc;
            if (prev_vld && !prev_rdy)
                check_dat("stall_stable", m_data, prev_dat);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_valid: data %0h with none expected (cycle %0d)", m_data, cyc);
            end else if (m_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check_dat("m_data", m_data, e.dat);
                check_int("m_last", int'(m_last), int'(e.last));
            end
            if (m_ready) begin
                n_pop++;
                last_pop_cyc = cyc;
            end
        end else if (prev_vld && !prev_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_dropped: m_valid fell while stalled (cycle %0d)", cyc);
        end
        prev_vld = m_valid;
        prev_rdy = m_ready;
        prev_dat = m_data;
    end

    task automatic issue(input int b, input int l, output int ts);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = AW'(b);
        len   = (AW + 1)'(l);
        ts    = cyc;
        first_rd  = -1;
        first_vld = -1;
        max_out   = 0;
        for (int i = 0; i < l; i++) begin
            int a;
            a = (b + i) % DEPTH;
            addr_q.push_back(a);
            exp_q.push_back('{last: (i == l - 1), dat: word(a)});
        end
        @(negedge clk);
        check_int("busy_before_start", int'(busy), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 400);
        dc = cyc;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", k);
        end
        check_int("busy_at_done", int'(busy), 1);
        @(negedge clk);
        check_int("busy_after_done", int'(busy), 0);
        check_int("done_pulse_width", int'(done), 0);
    endtask

    initial begin
        int t, dc, rd0, pop0, d0;
        #12;
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_rd_en", int'(mem_rd_en), 0);
        check_int("rst_rd_addr", int'(mem_rd_addr), 0);
        check_int("rst_m_valid", int'(m_valid), 0);
        check_int("rst_m_last", int'(m_last), 0);
        check_dat("rst_m_data", m_data, '0);
        @(negedge clk);
        #2 rstn = 1'b1;

        // Basic stream
        rdy_mode = 1;
        pop0 = n_pop;
        issue(10, 4, t);
        wait_done(dc);
        check_int("basic_first_rd", first_rd, t + 1);
        check_int("basic_first_vld", first_vld, t + 4);
        check_int("basic_last_pop", last_pop_cyc, t + 7);
        check_int("basic_done", dc, t + 8);
        check_int("basic_pops", n_pop - pop0, 4);

        // Wrap around the top of memory
        pop0 = n_pop;
        issue(1022, 4, t);
        wait_done(dc);
        check_int("wrap_first_rd", first_rd, t + 1);
        check_int("wrap_pops", n_pop - pop0, 4);
        check_int("wrap_done", dc, last_pop_cyc + 1);

        // Back-pressure: one accept every fourth cycle
        rdy_mode = 2;
        pop0 = n_pop;
        issue(300, 16, t);
        wait_done(dc);
        check_int("bp_max_outstanding", max_out, 5);
        check_int("bp_pops", n_pop - pop0, 16);
        check_int("bp_done", dc, last_pop_cyc + 1);

        // Zero length
        rdy_mode = 1;
        rd0 = n_rd;
        pop0 = n_pop;
        issue(5, 0, t);
        wait_done(dc);
        check_int("zero_done", dc, t + 1);
        check_int("zero_reads", n_rd - rd0, 0);
        check_int("zero_pops", n_pop - pop0, 0);

        // Second start during ISSUE is ignored
        rd0 = n_rd;
        pop0 = n_pop;
        d0 = done_cnt;
        issue(200, 6, t);
        start = 1'b1;
        base  = AW'(500);
        len   = (AW + 1)'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(dc);
        repeat (10) @(negedge clk);
        check_int("ign_reads", n_rd - rd0, 6);
        check_int("ign_pops", n_pop - pop0, 6);
        check_int("ign_done_count", done_cnt - d0, 1);
        check_int("ign_exp_left", exp_q.size(), 0);

        // Abort: reset with 2 reads in flight and 3 words buffered
        rdy_mode = 0;
        rd0 = n_rd;
        pop0 = n_pop;
        d0 = done_cnt;
        issue(100, 16, t);
        while (cyc < t + 7)
            @(negedge clk);
        #2;
        check_int("abort_reads_before", n_rd - rd0, 5);
        check_int("abort_valid_before", int'(m_valid), 1);
        rstn = 1'b0;
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_rd_en", int'(mem_rd_en), 0);
        check_int("abort_rd_addr", int'(mem_rd_addr), 0);
        check_int("abort_m_valid", int'(m_valid), 0);
        check_int("abort_m_last", int'(m_last), 0);
        check_dat("abort_m_data", m_data, '0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        first_vld = -1;
        repeat (8) @(negedge clk);
        check_int("abort_no_valid", first_vld, -1);
        check_int("abort_no_done", done_cnt - d0, 0);
        rdy_mode = 1;
        pop0 = n_pop;
        issue(0, 2, t);
        wait_done(dc);
        check_int("post_abort_first_vld", first_vld, t + 4);
        check_int("post_abort_pops", n_pop - pop0, 2);
        check_int("post_abort_done", dc, t + 6);

        repeat (5) @(negedge clk);
        check_int("final_exp_left", exp_q.size(), 0);
        check_int("final_addr_left", addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1);
    end
endmodule
